unidad_muldiv: RTL
==================

UNIDAD_MULDIV -- requirements
Module: unidad_muldiv

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled on the rising edge.
REQ-005 op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 op_a  input  32  first operand, driven from register-bank read port 1 (rs).
REQ-007 op_b  input  32  second operand, driven from register-bank read port 2 (rt).
REQ-008 mt_hi  input  1  write wdata into HI (MTHI).
REQ-009 mt_lo  input  1  write wdata into LO (MTLO).
REQ-010 wdata  input  32  data for mt_hi and mt_lo.
REQ-011 hi  output  32  registered HI: product upper word, or remainder.
REQ-012 lo  output  32  registered LO: product lower word, or quotient.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle pulse when hi and lo hold a new result.
REQ-015 div_zero  output  1  sticky flag: the last division had op_b == 0.

Function
REQ-016 The FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-017 busy SHALL be 1 in CALC and FIX only; done SHALL be 1 in DONE only.
REQ-018 start SHALL be accepted only in IDLE or DONE (back-to-back allowed). On the accepting edge: latch op, op_a and op_b; clear div_zero; load the iteration counter with 32; go to CALC.
REQ-019 start in CALC or FIX SHALL be ignored; the latched operands are unaffected.
REQ-020 Operand changes after the accepting edge SHALL NOT affect the result.
REQ-021 Signed ops SHALL operate on operand magnitudes; a sign-correction flag is recorded at accept.
REQ-022 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, for exactly 32 cycles, then go to FIX.
REQ-023 FIX SHALL apply sign correction, write hi and lo, and go to DONE.
- The edge that writes hi and lo is the 34th rising edge, counting the accepting edge as the 1st.
REQ-024 DONE SHALL last one cycle, then return to IDLE unless start is accepted.
REQ-025 Multiply SHALL produce the full 64-bit product, with {hi,lo} equal to the exact signed or unsigned product.
REQ-026 Signed divide SHALL truncate the quotient toward zero; the remainder takes the sign of the dividend.
REQ-027 The case 0x80000000 / 0xFFFFFFFF (DIV) SHALL give lo=0x80000000, hi=0.
REQ-028 Divide with op_b == 0 SHALL still take full latency and give lo=0xFFFFFFFF, hi=op_a (unmodified), div_zero=1.
- div_zero holds until the next accepted start or reset.
REQ-029 mt_hi and mt_lo SHALL update the register on the edge only in IDLE or DONE.
- They are ignored in CALC and FIX.
REQ-030 If start is accepted on the same edge as mt_hi or mt_lo, start SHALL win and the mt write SHALL be dropped.
REQ-031 If mt_hi and mt_lo are both high, both registers SHALL be written with wdata.
REQ-032 hi and lo SHALL hold their values between writes; no partial results appear on hi or lo during CALC.

Reset
REQ-033 While rst_n=0, independent of clk, the block SHALL force state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0 and counter=0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no result written.
- The first start after rst_n rises SHALL be accepted normally.

Verification
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at edge 34; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
REQ-036 MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Then DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, div_zero=1.
- A following MULTU 2 x 3 clears div_zero at accept and gives hi=0, lo=6.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-039 Start MULTU 2 x 3. At cycle 5, pulse start with op_a=9 and pulse mt_lo with wdata=0x1234.
- Both are ignored; the result is lo=6.
- Then in IDLE, mt_hi=1 with wdata=0xABCD -> hi=0xABCD, lo unchanged.
REQ-040 Start DIVU 100 / 7, then drop rst_n mid-edge at cycle 10 -> immediately hi=lo=0, busy=0, done=0.
- After release, DIVU 100 / 7 -> lo=14, hi=2.

Source files
------------

// File: rtl/unidad_muldiv.sv
// unidad_muldiv: iterative 32-bit multiply/divide unit with HI/LO registers.
// Multiply is shift-add, divide is restoring; both run on operand magnitudes
// for 32 cycles, then a FIX cycle applies sign correction and writes HI/LO.
module unidad_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nx;
    logic        accept;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_hi;
    logic        neg_lo;
    logic        b_zero;
    logic [31:0] a_raw;
    logic [31:0] b_mag;
    logic [31:0] w_hi;
    logic [31:0] w_lo;

    // Operand magnitudes and sign flags, evaluated on the accepting edge
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;

    // One iteration step and final correction values
    logic [32:0] m_sum;
    logic [32:0] d_shift;
    logic [32:0] d_diff;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand conditioning for the accept edge
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & op_a[31];
        b_neg     = signed_op & op_b[31];
        a_mag_in  = a_neg ? (~op_a + 32'd1) : op_a;
        b_mag_in  = b_neg ? (~op_b + 32'd1) : op_b;
        accept    = start && ((state == IDLE) || (state == DONE));
    end

    // Single iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        m_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, b_mag} : 33'd0);
        d_shift = {w_hi, w_lo[31]};
        d_diff  = d_shift - {1'b0, b_mag};
        step_hi = m_sum[32:1];
        step_lo = {m_sum[0], w_lo[31:1]};
        if (is_div) begin
            if (!d_diff[32]) begin
                step_hi = d_diff[31:0];
                step_lo = {w_lo[30:0], 1'b1};
            end else begin
                step_hi = d_shift[31:0];
                step_lo = {w_lo[30:0], 1'b0};
            end
        end
        prod_fix = neg_lo ? (~{w_hi, w_lo} + 64'd1) : {w_hi, w_lo};
        quo_fix  = neg_lo ? (~w_lo + 32'd1) : w_lo;
        rem_fix  = neg_hi ? (~w_hi + 32'd1) : w_hi;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = CALC;
            CALC: begin
                busy = 1'b1;
                if (cnt == 6'd1) state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = accept ? CALC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, result write-back and MTHI/MTLO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_hi   <= 1'b0;
            neg_lo   <= 1'b0;
            b_zero   <= 1'b0;
            a_raw    <= '0;
            b_mag    <= '0;
            w_hi     <= '0;
            w_lo     <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        cnt      <= 6'd32;
                        is_div   <= op[1];
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= op[1] & a_neg;
                        b_zero   <= (op_b == 32'd0);
                        a_raw    <= op_a;
                        b_mag    <= b_mag_in;
                        w_hi     <= '0;
                        w_lo     <= a_mag_in;
                        div_zero <= 1'b0;
                    end else begin
                        if (mt_hi) hi <= wdata;
                        if (mt_lo) lo <= wdata;
                    end
                end
                CALC: begin
                    w_hi <= step_hi;
                    w_lo <= step_lo;
                    cnt  <= cnt - 6'd1;
                end
                FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (b_zero) begin
                        // Divide by zero reports the raw dividend, not its magnitude
                        hi       <= a_raw;
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
